// File: rtl/switch_ramp_gen.sv
// Thermometer ramp generator: walks 15 switch lines one step per DWELL cycles toward a 4-bit target.
// Optional abort/aborted ports are enabled with the SWITCH_RAMP_ABORT_EN macro.
module switch_ramp_gen #(
  parameter int unsigned DWELL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  target,
`ifdef SWITCH_RAMP_ABORT_EN
  input  logic        abort,
  output logic        aborted,
`endif
  output logic [14:0] sw,
  output logic [3:0]  cnt,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

  logic [1:0]  state_q, state_d, phase;
  logic [7:0]  dcnt_q, dcnt_d;
  logic [3:0]  tgt_q, tgt_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [14:0] sw_q, sw_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        abort_hit;
`ifdef SWITCH_RAMP_ABORT_EN
  logic        aborted_q, aborted_d;
`endif

  always_comb begin
    // The step is taken on the edge where the dwell counter has run out, so
    // the first change lands exactly DWELL edges after the start edge.
    phase = state_q;
    if (state_q == S_WAIT && dcnt_q == 8'd0) phase = S_STEP;

    abort_hit = 1'b0;
`ifdef SWITCH_RAMP_ABORT_EN
    abort_hit = abort && (phase == S_WAIT || phase == S_STEP);
`endif

    state_d = state_q;
    dcnt_d  = dcnt_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;

    case (phase)
      S_IDLE: begin
        if (start) begin
          tgt_d = target;
          if (target == cnt_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            dcnt_d  = DWELL_M1;
          end
        end
      end
      S_WAIT: dcnt_d = dcnt_q - 8'd1;
      S_STEP: begin
        cnt_d = (tgt_q > cnt_q) ? 4'(cnt_q + 4'd1) : 4'(cnt_q - 4'd1);
        if (cnt_d == tgt_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          dcnt_d  = DWELL_M1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_hit) begin
      cnt_d   = cnt_q;
      dcnt_d  = 8'd0;
      state_d = S_DONE;
    end

    busy_d = (state_d == S_WAIT);
    done_d = (state_d == S_DONE);
    sw_d   = 15'((16'd1 << cnt_d) - 16'd1);
`ifdef SWITCH_RAMP_ABORT_EN
    aborted_d = abort_hit;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dcnt_q    <= 8'd0;
      tgt_q     <= 4'd0;
      cnt_q     <= 4'd0;
      sw_q      <= 15'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SWITCH_RAMP_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      sw_q      <= sw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SWITCH_RAMP_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign sw   = sw_q;
  assign cnt  = cnt_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SWITCH_RAMP_ABORT_EN
  assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_switch_ramp_gen.sv
// Bench for switch_ramp_gen: two instances (DWELL=4 and DWELL=1) checked every cycle
// against a closed-form ramp model, plus directed literal checks.
module tb_switch_ramp_gen;

  localparam int DW [2] = '{4, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  target;
  logic [14:0] sw_o   [2];
  logic [3:0]  cnt_o  [2];
  logic        busy_o [2];
  logic        done_o [2];
`ifdef SWITCH_RAMP_ABORT_EN
  logic        abort;
  logic        aborted_o [2];
`endif

  always #5 clk = ~clk;

  switch_ramp_gen #(.DWELL(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
`ifdef SWITCH_RAMP_ABORT_EN
    .abort(abort), .aborted(aborted_o[0]),
`endif
    .sw(sw_o[0]), .cnt(cnt_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  switch_ramp_gen #(.DWELL(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
`ifdef SWITCH_RAMP_ABORT_EN
    .abort(abort), .aborted(aborted_o[1]),
`endif
    .sw(sw_o[1]), .cnt(cnt_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  // Model: a ramp accepted at edge c0 from cnt0 has taken min((e-c0)/D, nst)
  // steps after edge e, and ends (done) at edge endc.
  int ec;
  int c0 [2], cnt0 [2], nst [2], dir [2], endc [2], abt [2];
  int npass = 0, ntotal = 0;
  bit chk_en = 1'b0;

  function automatic int cur_cnt(int i, int e);
    int s;
    s = (e - c0[i]) / DW[i];
    if (s > nst[i]) s = nst[i];
    return cnt0[i] + dir[i] * s;
  endfunction

  function automatic int absd(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ec <= 0;
      for (int i = 0; i < 2; i++) begin
        c0[i] <= 0; cnt0[i] <= 0; nst[i] <= 0; dir[i] <= 1; endc[i] <= -100; abt[i] <= 0;
      end
    end else begin
      ec <= ec + 1;
      for (int i = 0; i < 2; i++) begin
        if (start && ec + 1 >= endc[i] + 2) begin
          c0[i]   <= ec + 1;
          cnt0[i] <= cur_cnt(i, ec);
          nst[i]  <= absd(int'(target), cur_cnt(i, ec));
          dir[i]  <= (int'(target) >= cur_cnt(i, ec)) ? 1 : -1;
          endc[i] <= ec + 1 + absd(int'(target), cur_cnt(i, ec)) * DW[i];
          abt[i]  <= 0;
        end
`ifdef SWITCH_RAMP_ABORT_EN
        else if (abort && ec + 1 > c0[i] && ec + 1 <= endc[i]) begin
          nst[i]  <= (ec - c0[i]) / DW[i];
          endc[i] <= ec + 1;
          abt[i]  <= 1;
        end
`endif
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cnt%0d", i), int'(cnt_o[i]), cur_cnt(i, ec));
        chk($sformatf("sw%0d", i), int'(sw_o[i]), (1 << cur_cnt(i, ec)) - 1);
        chk($sformatf("busy%0d", i), int'(busy_o[i]), int'(ec < endc[i]));
        chk($sformatf("done%0d", i), int'(done_o[i]), int'(ec == endc[i]));
`ifdef SWITCH_RAMP_ABORT_EN
        chk($sformatf("aborted%0d", i), int'(aborted_o[i]), int'(ec == endc[i] && abt[i] != 0));
`endif
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input int tg);
    target = 4'(tg);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    int k;
    k = 0;
    while (int'(cnt_o[0]) != v && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wait_cnt", int'(cnt_o[0]), v);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; target = 4'd0;
`ifdef SWITCH_RAMP_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_sw", int'(sw_o[0]), 0);
    chk("rst_busy", int'(busy_o[0]), 0);
    chk("rst_done", int'(done_o[0]), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // 0 -> 5 at DWELL=4: first change at E0+4, last at E0+20
    go(5);
    idle(3);
    chk("s1_sw_e3", int'(sw_o[0]), 'h0);
    chk("s1_busy_e3", int'(busy_o[0]), 1);
    idle(1);
    chk("s1_sw_e4", int'(sw_o[0]), 'h1);
    idle(16);
    chk("s1_sw_e20", int'(sw_o[0]), 'h1F);
    chk("s1_done_e20", int'(done_o[0]), 1);
    chk("s1_busy_e20", int'(busy_o[0]), 0);
    idle(1);
    chk("s1_done_e21", int'(done_o[0]), 0);
    idle(2);

    // 5 -> 2
    go(2);
    idle(12);
    chk("s2_sw", int'(sw_o[0]), 'h3);
    chk("s2_done", int'(done_o[0]), 1);
    idle(2);

    // target equals current count
    go(2);
    chk("s3_done", int'(done_o[0]), 1);
    chk("s3_busy", int'(busy_o[0]), 0);
    chk("s3_sw", int'(sw_o[0]), 'h3);
    idle(2);

    // 2 -> 15 with ignored starts and target churn mid-ramp
    go(15);
    for (int k = 0; k < 8; k++) begin
      start = 1'b1;
      target = 4'($urandom_range(0, 15));
      idle(1);
    end
    start = 1'b0;
    idle(50);
    chk("s4_sw0", int'(sw_o[0]), 'h7FFF);
    chk("s4_sw1", int'(sw_o[1]), 'h7FFF);
    idle(2);

    // async reset mid-ramp
    go(0);
    wait_cnt(7);
    #1 rst_n = 1'b0;
    #1;
    chk("s5_sw", int'(sw_o[0]), 0);
    chk("s5_busy", int'(busy_o[0]), 0);
    chk("s5_done", int'(done_o[0]), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    go(5);
    idle(3);
    chk("s5b_sw_e3", int'(sw_o[0]), 'h0);
    idle(1);
    chk("s5b_sw_e4", int'(sw_o[0]), 'h1);
    idle(18);

`ifdef SWITCH_RAMP_ABORT_EN
    go(0);
    idle(25);
    go(10);
    wait_cnt(6);
    #1 abort = 1'b1;
    idle(1);
    abort = 1'b0;
    chk("ab_sw", int'(sw_o[0]), 'h3F);
    chk("ab_done", int'(done_o[0]), 1);
    chk("ab_aborted", int'(aborted_o[0]), 1);
    idle(2);
    go(10);
    idle(16);
    chk("ab_resume", int'(cnt_o[0]), 10);
    idle(2);
`endif

    for (int k = 0; k < 400; k++) begin
      start  = ($urandom_range(0, 3) == 0);
      target = 4'($urandom_range(0, 15));
`ifdef SWITCH_RAMP_ABORT_EN
      abort  = ($urandom_range(0, 15) == 0);
`endif
      idle(1);
    end
    start = 1'b0;
`ifdef SWITCH_RAMP_ABORT_EN
    abort = 1'b0;
`endif
    idle(70);
    chk("end_idle0", int'(busy_o[0]), 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
